// File: rtl/word_collector.sv
// Serial-to-parallel word collector: packs up to N_WORDS stream words into a
// zero-padded frame and holds it until the downstream side acknowledges it.
module word_collector #(
  parameter int WORD_W  = 25,
  parameter int N_WORDS = 16,
  parameter int CNT_W   = $clog2(N_WORDS) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [N_WORDS*WORD_W-1:0] frame_data,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic                      frame_valid,
  input  logic                      frame_ack
);

  localparam int PTR_W = CNT_W - 1;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]        state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [WORD_W-1:0] slot [N_WORDS];
  logic              xfer;
  logic              frame_done;
  logic              release_frame;

  assign xfer          = (state == ST_FILL) && in_ready && in_valid;
  assign frame_done    = xfer && (in_last || (wr_ptr == PTR_W'(N_WORDS - 1)));
  assign release_frame = (state == ST_HOLD) && frame_ack;

  // in_ready comes up one edge after reset release, so it can sit low in FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FILL;
      wr_ptr      <= '0;
      in_ready    <= 1'b0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (xfer) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (frame_done) begin
              frame_valid <= 1'b1;
              frame_cnt   <= {1'b0, wr_ptr} + CNT_W'(1);
              in_ready    <= 1'b0;
              state       <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (frame_ack) begin
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            wr_ptr      <= '0;
            in_ready    <= 1'b1;
            state       <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  // Slots clear on release so a short next frame is implicitly zero-padded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WORDS; i++) slot[i] <= '0;
    end else if (release_frame) begin
      for (int i = 0; i < N_WORDS; i++) slot[i] <= '0;
    end else if (xfer) begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (wr_ptr == PTR_W'(i)) slot[i] <= in_data;
      end
    end
  end

  always_comb begin
    frame_data = '0;
    for (int i = 0; i < N_WORDS; i++) frame_data[i*WORD_W +: WORD_W] = slot[i];
  end

endmodule

// File: tb/tb_word_collector.sv
// Self-checking bench for word_collector: directed scenarios plus random
// traffic, checked every cycle against a queue-based frame model.
module tb_word_collector;

  localparam int WORD_W  = 25;
  localparam int N_WORDS = 16;
  localparam int CNT_W   = 5;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [WORD_W-1:0]         in_data;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic [N_WORDS*WORD_W-1:0] frame_data;
  logic [CNT_W-1:0]          frame_cnt;
  logic                      frame_valid;
  logic                      frame_ack;

  int n_cmp = 0;
  int n_err = 0;

  word_collector #(.WORD_W(WORD_W), .N_WORDS(N_WORDS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .frame_data  (frame_data),
    .frame_cnt   (frame_cnt),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack)
  );

  always #5 clk = ~clk;

  // Reference model: the words of the current frame, whether it is held,
  // and whether the collector is ready.
  logic [WORD_W-1:0] q[$];
  bit                m_hold;
  bit                m_ready;

  task automatic model_reset();
    q.delete();
    m_hold  = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic model_edge();
    if (m_hold) begin
      if (frame_ack === 1'b1) begin
        q.delete();
        m_hold  = 1'b0;
        m_ready = 1'b1;
      end
    end else if (!m_ready) begin
      m_ready = 1'b1;
    end else if (in_valid === 1'b1) begin
      q.push_back(in_data);
      if (in_last === 1'b1 || q.size() == N_WORDS) begin
        m_hold  = 1'b1;
        m_ready = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [N_WORDS*WORD_W-1:0] e_data;
    logic [CNT_W-1:0]          e_cnt;
    e_data = '0;
    foreach (q[i]) e_data[i*WORD_W +: WORD_W] = q[i];
    e_cnt = m_hold ? CNT_W'(q.size()) : '0;
    n_cmp += 4;
    assert (in_ready === m_ready) else begin
      n_err++;
      $error("FAIL %s in_ready: observed %b expected %b", tag, in_ready, m_ready);
    end
    assert (frame_valid === m_hold) else begin
      n_err++;
      $error("FAIL %s frame_valid: observed %b expected %b", tag, frame_valid, m_hold);
    end
    assert (frame_cnt === e_cnt) else begin
      n_err++;
      $error("FAIL %s frame_cnt: observed %0d expected %0d", tag, frame_cnt, e_cnt);
    end
    assert (frame_data === e_data) else begin
      n_err++;
      $error("FAIL %s frame_data: observed %h expected %h", tag, frame_data, e_data);
    end
  endtask

  // Inputs change only at the falling edge; the model uses them before the
  // rising edge and outputs are checked at the next falling edge.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check(tag);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick({tag, "_release"});
  endtask

  initial begin
    int vlen;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    frame_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset");
    rst_n = 1'b1;
    tick("ready_rise");

    // Full frame of 1..16 with IN_VALID held high.
    in_valid = 1'b1;
    for (int i = 0; i < N_WORDS; i++) begin
      in_data = WORD_W'(i + 1);
      tick("full_fill");
    end
    in_valid = 1'b0;
    tick("full_hold");
    frame_ack = 1'b1;
    tick("full_ack");
    frame_ack = 1'b0;

    // Short frame with IN_LAST on the third word.
    in_valid = 1'b1;
    in_data = 25'h1FFFFFF; tick("short_w0");
    in_data = 25'd5;       tick("short_w1");
    in_data = 25'd7; in_last = 1'b1; tick("short_w2");
    in_last = 1'b0;

    // Backpressure while held: nothing captured until after the ACK edge.
    in_data = 25'h0AA;
    repeat (10) tick("bp_hold");
    frame_ack = 1'b1;
    tick("bp_ack");
    frame_ack = 1'b0;
    tick("bp_capture");
    in_valid = 1'b0;
    tick("bp_idle");
    in_valid = 1'b1; in_last = 1'b1; in_data = 25'd1;
    tick("bp_close");
    in_valid = 1'b0; in_last = 1'b0;
    frame_ack = 1'b1;
    tick("bp_ack2");
    frame_ack = 1'b0;

    // Gapped input with X on the data bus while invalid.
    for (int n = 0; n < 32; n++) begin
      in_valid = (n % 2 == 0);
      in_data  = in_valid ? WORD_W'(32'h100 + n) : 'x;
      tick("gapped");
    end
    in_data = '0;
    frame_ack = 1'b1;
    tick("gapped_ack");
    frame_ack = 1'b0;

    // Random traffic, including spurious ACKs during FILL.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = in_valid ? WORD_W'($urandom) : 'x;
      in_last   = ($urandom_range(0, 7) == 0);
      frame_ack = ($urandom_range(0, 3) == 0);
      tick("random");
    end
    in_valid = 1'b0; in_last = 1'b0; frame_ack = 1'b0; in_data = '0;
    tick("random_end");
    if (m_hold) begin
      frame_ack = 1'b1;
      tick("random_ack");
      frame_ack = 1'b0;
    end

    // Reset after 7 words, then a fresh 16-word frame, then reset in HOLD.
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = WORD_W'($urandom);
      tick("pre_rst_fill");
    end
    async_reset("rst_mid_fill");
    in_valid = 1'b1;
    for (int i = 0; i < N_WORDS; i++) begin
      in_data = WORD_W'($urandom);
      tick("post_rst_fill");
    end
    in_valid = 1'b0;
    tick("post_rst_hold");
    async_reset("rst_in_hold");

    // ACK tied high: each frame valid for exactly one cycle.
    frame_ack = 1'b1;
    in_valid  = 1'b1;
    vlen = 0;
    for (int n = 0; n < 80; n++) begin
      in_data = WORD_W'($urandom);
      in_last = ($urandom_range(0, 3) == 0);
      tick("ack_tied");
      if (frame_valid === 1'b1) vlen++;
      else vlen = 0;
      n_cmp++;
      assert (vlen <= 1) else begin
        n_err++;
        $error("FAIL ack_tied_len: observed %0d expected <=1", vlen);
      end
    end
    frame_ack = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
